mem_port_arbiter: RTL

//  Shares one single-port unified memory between the CPU instruction-fetch path and the

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_prio_sel.sv | 28 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_port_arbiter_pkg
// Desc     : Shared state/owner codes, counter widths and helpers for the
//            unified-memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam logic [0:0] OWN_IF   = 1'b0;
    localparam logic [0:0] OWN_D    = 1'b1;

    // Latency counter holds MEM_LAT up to 4; starvation counter holds up to 15.
    localparam int LAT_W    = 3;
    localparam int STARVE_W = 4;

    function automatic logic [STARVE_W-1:0] starve_inc(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] max
    );
        return (cnt >= max) ? max : cnt + STARVE_W'(1);
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_prio_sel.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_prio_sel
// Desc     : Combinational requester select: data first, fetch once starved.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter_prio_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                sel_if,
    output logic                sel_d
);

    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_MAX);

    logic w_starved;

    assign w_starved = (starve_cnt == c_STARVE_MAX);
    assign sel_if    = if_req & (~d_req | w_starved);
    assign sel_d     = d_req & ~sel_if;

endmodule : mem_port_arbiter_prio_sel
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Desc     : Shares one single-port memory between instruction fetch and
//            load/store; one access in flight, response routed to its owner.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int                  STRB_W     = DATA_W / 8;
    localparam logic [LAT_W-1:0]    c_LAT_INIT = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0]    c_LAT_LAST = LAT_W'(1);
    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_MAX);

    logic [0:0]          r_state;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [0:0]          r_owner;
    logic                r_we;

    logic w_resp_cycle;
    logic w_resp;
    logic w_can_issue;
    logic w_sel_if;
    logic w_sel_d;
    logic w_if_issue;
    logic w_d_issue;
    logic w_issue;

    mem_port_arbiter_prio_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_sel (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (r_starve_cnt),
        .sel_if     (w_sel_if),
        .sel_d      (w_sel_d)
    );

    // The response cycle doubles as an issue slot, giving one access per MEM_LAT.
    assign w_resp_cycle = (r_state == ARB_BUSY) && (r_lat_cnt == c_LAT_LAST);
    assign w_resp       = w_resp_cycle && !reset;
    assign w_can_issue  = !reset && ((r_state == ARB_IDLE) || w_resp_cycle);
    assign w_if_issue   = w_can_issue & w_sel_if;
    assign w_d_issue    = w_can_issue & w_sel_d;
    assign w_issue      = w_if_issue | w_d_issue;

    assign if_gnt    = w_if_issue;
    assign d_gnt     = w_d_issue;

    assign mem_en    = w_issue;
    assign mem_we    = w_d_issue & d_we;
    assign mem_addr  = w_d_issue  ? d_addr  :
                       w_if_issue ? if_addr : {ADDR_W{1'b0}};
    assign mem_wdata = w_d_issue  ? d_wdata : {DATA_W{1'b0}};
    assign mem_wstrb = w_d_issue  ? d_wstrb : {STRB_W{1'b0}};

    assign if_rvalid = w_resp & (r_owner == OWN_IF);
    assign d_rvalid  = w_resp & (r_owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : {DATA_W{1'b0}};
    assign d_rdata   = (d_rvalid & ~r_we) ? mem_rdata : {DATA_W{1'b0}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_lat_cnt <= '0;
            r_owner   <= OWN_IF;
            r_we      <= 1'b0;
        end else if (w_issue) begin
            r_state   <= ARB_BUSY;
            r_lat_cnt <= c_LAT_INIT;
            r_owner   <= w_d_issue ? OWN_D : OWN_IF;
            r_we      <= w_d_issue & d_we;
        end else begin
            case (r_state)
                ARB_BUSY: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_state   <= ARB_IDLE;
                        r_lat_cnt <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - c_LAT_LAST;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_lat_cnt <= '0;
                end
            endcase
        end
    end

    // Counts data grants that jumped a waiting fetch; a fetch grant or idle fetch resets it.
    always_ff @(posedge clk) begin
        if (reset || !if_req || w_if_issue) begin
            r_starve_cnt <= '0;
        end else if (w_d_issue) begin
            r_starve_cnt <= starve_inc(r_starve_cnt, c_STARVE_MAX);
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire
